// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - bin over WIDTH/DIGIT cycles, LSB digit first,
// with a start/busy/done handshake and registered borrow, overflow and zero flags.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NDIG - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] diff_sr_reg;
  logic             borrow_reg;
  logic [CNT_W-1:0] count_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;

  // One ripple of DIGIT full-subtract cells fed by the registered borrow.
  logic [DIGIT:0]   br_chain;
  logic [DIGIT-1:0] d_digit;

  assign br_chain[0] = borrow_reg;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
    logic cell_x;
    logic cell_y;
    assign cell_x           = a_sr_reg[gi];
    assign cell_y           = b_sr_reg[gi];
    assign d_digit[gi]      = cell_x ^ cell_y ^ br_chain[gi];
    assign br_chain[gi+1]   = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & br_chain[gi]);
  end

  // New digit enters from the MSB side; after NDIG shifts the word is aligned.
  logic [WIDTH-1:0] diff_sr_next;
  logic             borrow_next;
  logic             ovf_next;

  assign diff_sr_next = (diff_sr_reg >> DIGIT) | (WIDTH'(d_digit) << (WIDTH - DIGIT));
  assign borrow_next  = br_chain[DIGIT];
  assign ovf_next     = (a_msb_reg != b_msb_reg) && (diff_sr_next[WIDTH-1] != a_msb_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_sr_reg    <= '0;
      b_sr_reg    <= '0;
      diff_sr_reg <= '0;
      borrow_reg  <= 1'b0;
      count_reg   <= '0;
      a_msb_reg   <= 1'b0;
      b_msb_reg   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      diff        <= '0;
      bout        <= 1'b0;
      ovf         <= 1'b0;
      zero        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr_reg    <= a;
            b_sr_reg    <= b;
            diff_sr_reg <= '0;
            borrow_reg  <= bin;
            count_reg   <= '0;
            a_msb_reg   <= a[WIDTH-1];
            b_msb_reg   <= b[WIDTH-1];
            busy        <= 1'b1;
            state_reg   <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_sr_reg    <= a_sr_reg >> DIGIT;
          b_sr_reg    <= b_sr_reg >> DIGIT;
          diff_sr_reg <= diff_sr_next;
          borrow_reg  <= borrow_next;
          count_reg   <= count_reg + CNT_W'(1);
          if (count_reg == LAST_COUNT) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            diff      <= diff_sr_next;
            bout      <= borrow_next;
            ovf       <= ovf_next;
            zero      <= (diff_sr_next == '0);
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three configurations (1/1, 8/1, 8/4) checked against an
// arithmetic reference model, plus handshake, back-to-back, ignored-start and reset cases.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st1, st8, st4;
  logic       a1, b1, bin1;
  logic [7:0] a8, b8, a4, b4;
  logic       bin8, bin4;
  logic       busy1, busy8, busy4;
  logic       done1, done8, done4;
  logic       diff1;
  logic [7:0] diff8, diff4;
  logic       bout1, bout8, bout4;
  logic       ovf1, ovf8, ovf4;
  logic       zero1, zero8, zero4;

  int errs = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1), .zero(zero1));

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4), .zero(zero4));

  // k: 0 = W1/D1, 1 = W8/D1, 2 = W8/D4
  task automatic drive(input int k, input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi);
    case (k)
      0: begin st1 = s; a1 = av[0]; b1 = bv[0]; bin1 = bi; end
      1: begin st8 = s; a8 = av; b8 = bv; bin8 = bi; end
      default: begin st4 = s; a4 = av; b4 = bv; bin4 = bi; end
    endcase
  endtask

  task automatic drive_junk(input int k);
    drive(k, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  // {busy, done, bout, ovf, zero, diff[7:0]}
  function automatic logic [12:0] obs(input int k);
    case (k)
      0:       return {busy1, done1, bout1, ovf1, zero1, 7'd0, diff1};
      1:       return {busy8, done8, bout8, ovf8, zero8, diff8};
      default: return {busy4, done4, bout4, ovf4, zero4, diff4};
    endcase
  endfunction

  // Reference: plain integer arithmetic on a w-bit word; returns {bout, ovf, zero, diff[7:0]}.
  function automatic logic [10:0] model(input int w, input int unsigned av, input int unsigned bv,
                                        input int unsigned bi);
    int unsigned m;
    int unsigned d;
    int sa, sb, r;
    logic bo, ov;
    m  = (1 << w) - 1;
    d  = (av - bv - bi) & m;
    bo = (av < bv + bi);
    sa = (av >= (1 << (w - 1))) ? int'(av) - (1 << w) : int'(av);
    sb = (bv >= (1 << (w - 1))) ? int'(bv) - (1 << w) : int'(bv);
    r  = sa - sb - int'(bi);
    ov = (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
    return {bo, ov, (d == 0), d[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 0) ? 1 : 8;
  endfunction

  function automatic int ndig_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 8 : 2);
  endfunction

  // Full transaction from idle: latency, busy, output hold, result and one-cycle done.
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input string tag);
    logic [12:0] prev;
    logic [12:0] o;
    logic [10:0] e;
    int n;
    bit seen;
    e    = model(width_of(k), av, bv, bi);
    prev = obs(k);
    drive(k, 1'b1, av, bv, bi);
    @(posedge clk); #1;
    drive_junk(k);
    o = obs(k);
    check({tag, " busy@accept"}, o[12], 1'b1);
    check({tag, " hold@accept"}, o[10:0], prev[10:0]);
    n = 0;
    seen = 0;
    repeat (40) begin
      if (!seen) begin
        @(posedge clk); #1;
        n++;
        o = obs(k);
        if (o[11]) seen = 1;
        else begin
          check($sformatf("%s busy@%0d", tag, n), o[12], 1'b1);
          check($sformatf("%s hold@%0d", tag, n), o[10:0], prev[10:0]);
        end
      end
    end
    check({tag, " done seen"}, seen, 1'b1);
    check({tag, " latency"}, n, ndig_of(k));
    check({tag, " busy@done"}, o[12], 1'b0);
    check({tag, " result"}, o[10:0], e);
    @(posedge clk); #1;
    o = obs(k);
    check({tag, " done pulse"}, o[11], 1'b0);
    check({tag, " result hold"}, o[10:0], e);
    $display("op %s k=%0d a=%0h b=%0h bin=%0d -> diff=%0h bout=%0d ovf=%0d zero=%0d lat=%0d",
             tag, k, av, bv, bi, o[7:0], o[10], o[9], o[8], n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] o;
    logic [10:0] e;
    int n;
    bit seen;
    bit any_done;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("reset state k=%0d", k), obs(k), 13'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-subtractor truth table on the 1-bit instance
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op(0, {7'd0, v[2]}, {7'd0, v[1]}, v[0], $sformatf("fs%0d", i));
    end

    // Directed cases
    run_op(1, 8'h5A, 8'h3C, 1'b0, "w8d1 5A-3C");
    check("w8d1 5A-3C diff", diff8, 8'h1E);
    run_op(2, 8'h00, 8'h01, 1'b0, "w8d4 00-01");
    check("w8d4 00-01 diff/bout", {bout4, ovf4, diff4}, {1'b1, 1'b0, 8'hFF});
    run_op(2, 8'h80, 8'h01, 1'b0, "w8d4 80-01");
    check("w8d4 80-01 diff/ovf", {bout4, ovf4, diff4}, {1'b0, 1'b1, 8'h7F});
    run_op(2, 8'h10, 8'h0F, 1'b1, "w8d4 10-0F-1");
    check("w8d4 10-0F-1 zero", {zero4, bout4, diff4}, {1'b1, 1'b0, 8'h00});

    // Randomized operations
    for (int i = 0; i < 10; i++) begin
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd8d1_%0d", i));
      run_op(2, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd8d4_%0d", i));
      run_op(0, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), 1'($urandom),
             $sformatf("rnd1_%0d", i));
    end

    // Start pulsed mid-RUN with other operands must be ignored
    e = model(8, 32'h12, 32'h34, 0);
    drive(1, 1'b1, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h12, 8'h34, 1'b0);
    n = 0;
    seen = 0;
    repeat (40) begin
      if (!seen) begin
        @(posedge clk); #1;
        n++;
        if (n == 2) drive(1, 1'b1, 8'hFF, 8'h01, 1'b1);
        if (n == 3) drive(1, 1'b0, 8'hFF, 8'h01, 1'b1);
        if (done8) seen = 1;
      end
    end
    check("midstart done seen", seen, 1'b1);
    check("midstart latency", n, 8);
    check("midstart result", {bout8, ovf8, zero8, diff8}, e);
    @(posedge clk); #1;
    check("midstart no rerun", {busy8, done8}, 2'b00);
    $display("op midstart a=12 b=34 -> diff=%0h lat=%0d", diff8, n);

    // Back-to-back: start held high through DONE
    drive(2, 1'b1, 8'hC3, 8'h5A, 1'b1);
    @(posedge clk); #1;
    n = 0;
    seen = 0;
    repeat (40) begin
      if (!seen) begin
        @(posedge clk); #1;
        n++;
        if (done4) seen = 1;
      end
    end
    check("b2b first done seen", seen, 1'b1);
    check("b2b first latency", n, 2);
    check("b2b first result", {bout4, ovf4, zero4, diff4}, model(8, 32'hC3, 32'h5A, 1));
    drive(2, 1'b1, 8'h21, 8'h7E, 1'b0);
    @(posedge clk); #1;
    check("b2b accept busy/done", {busy4, done4}, 2'b10);
    check("b2b hold first", {bout4, ovf4, zero4, diff4}, model(8, 32'hC3, 32'h5A, 1));
    drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
    n = 1;
    seen = 0;
    repeat (40) begin
      if (!seen) begin
        @(posedge clk); #1;
        n++;
        if (done4) seen = 1;
      end
    end
    check("b2b second done seen", seen, 1'b1);
    check("b2b done spacing", n, 3);
    check("b2b second result", {bout4, ovf4, zero4, diff4}, model(8, 32'h21, 32'h7E, 0));
    $display("op b2b C3-5A-1 then 21-7E -> diff=%0h spacing=%0d", diff4, n);
    @(posedge clk); #1;

    // Reset during RUN aborts and clears outputs
    run_op(1, 8'h80, 8'h01, 1'b1, "w8d1 pre-reset");
    drive(1, 1'b1, 8'h5A, 8'h3C, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h5A, 8'h3C, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    o = obs(1);
    check("rst midrun outputs", o, 13'd0);
    any_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) any_done = 1;
    end
    check("rst midrun no done", any_done, 1'b0);
    $display("op reset-midrun busy=%0d done=%0d diff=%0h", o[12], o[11], o[7:0]);
    run_op(1, 8'h5A, 8'h3C, 1'b0, "w8d1 post-reset");
    check("post-reset diff", diff8, 8'h1E);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, digit-serial N-bit subtractor. Computes diff = a - b - bin using DIGIT full-subtract cells per clock, LSB digit first.
- The borrow is carried between cycles in a register.
- Successor to the single-bit full subtractor. Used wherever wide subtraction is needed at low area, with a start/busy/done handshake to a controller.
- Adds status flags: final borrow, signed overflow and zero.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be >= 1.
- DIGIT, 1, bits processed per clock. WIDTH % DIGIT == 0 is required; elaboration fails otherwise.
- Derived: NDIG = WIDTH/DIGIT, the number of compute cycles. Counter width = clog2(NDIG+1).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only when the block is idle or done.
- a  input  WIDTH  minuend. Captured on the accepting edge.
- b  input  WIDTH  subtrahend. Captured on the accepting edge.
- bin  input  1  borrow-in. Captured on the accepting edge.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow out; 1 when a < b + bin (unsigned).
- ovf  output  1  two's-complement overflow of a - b - bin.
- zero  output  1  diff == 0.

Behaviour:
- Reset:
  - Reset is synchronous on clk and active-high.
  - State goes to IDLE. busy=0, done=0, diff=0, bout=0, ovf=0, zero=0.
  - Internal shift registers, the borrow flop and the counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Capture a, b into shift registers. Load borrow flop with bin. count=0.
  - Go to RUN; busy=1 from E0.
- RUN, each edge E1..E_NDIG:
  - Process the low DIGIT bits of each shift register as a ripple of full-subtract cells.
  - Per bit: d = x ^ y ^ br; br' = (~x & y) | (~(x ^ y) & br).
  - Shift result bits into the diff shift register from the MSB side. Update the borrow flop. count++.
- At edge E_NDIG:
  - Go to DONE. busy=0, done=1.
  - diff takes the assembled result; bout takes the final borrow.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
  - zero = (diff == 0).
- Latency: done is high in the cycle after edge E_NDIG, i.e. NDIG cycles after the accepting edge. Throughput is one operation per NDIG+1 cycles.
- DONE:
  - Lasts exactly one cycle.
  - start=1 is accepted exactly as in IDLE and goes straight to RUN (back-to-back operation). Otherwise go to IDLE.
- Output hold: diff, bout, ovf and zero hold their last values until the next DONE, including throughout the next RUN. They change only at the DONE edge or on reset.
- start during RUN is ignored. It has no effect on operands or count.
- Operand changes on a, b, bin after the accepting edge have no effect.
- Reset asserted mid-RUN: on the next edge, abort to IDLE with all outputs cleared. No done pulse is issued. Reset has priority over start.
- Degenerate case WIDTH=1, DIGIT=1: behaves as a registered full subtractor with latency 1.
- DIGIT=WIDTH: NDIG=1, so there is a single compute cycle.

Test Plan:
- WIDTH=1, DIGIT=1, all 8 {a,b,bin} combinations -> diff/bout match the full-subtractor truth table: 000→0/0, 001→1/1, 010→1/1, 011→0/1, 100→1/0, 101→0/0, 110→0/0, 111→1/1. done appears 1 cycle after start.
- WIDTH=8, DIGIT=1:
  - 0x5A-0x3C, bin=0 -> diff=0x1E, bout=0, ovf=0, zero=0.
  - done appears exactly 8 cycles after the start edge, with busy high for those cycles.
- WIDTH=8, DIGIT=4:
  - 0x00-0x01, bin=0 -> diff=0xFF, bout=1, ovf=0, latency 2.
  - 0x80-0x01 -> diff=0x7F, ovf=1, bout=0.
  - 0x10-0x0F, bin=1 -> diff=0x00, zero=1, bout=0.
- Start pulsed mid-RUN with different operands -> ignored; the first result is unchanged.
- Start held high through DONE -> the second operation starts without an IDLE cycle; its done follows NDIG+1 cycles after the first done.
- rst asserted at the 3rd RUN cycle (WIDTH=8, DIGIT=1) -> next cycle busy=0, all outputs 0, no done pulse. A subsequent 0x5A-0x3C gives the correct 0x1E.
